// File: rtl/fc_layer_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared CNN types, FC state encoding and layer address map.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int WORD_W    = 16;
    localparam int FRAC_BITS = 8;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        FC_IDLE    = 3'd0,
        FC_RD_BIAS = 3'd1,
        FC_RD_X    = 3'd2,
        FC_RD_W    = 3'd3,
        FC_MAC     = 3'd4,
        FC_WR_Y    = 3'd5,
        FC_DONE    = 3'd6
    } fc_state_e;

    // Weights start at the FC layer origin; the feature vector and biases sit just below it.
    localparam logic [15:0] FC_STARTING_ADDRESS = 16'd59716;
    localparam logic [15:0] FC_IMAGE_BASE       = 16'd59596;
    localparam logic [15:0] FC_BIAS_BASE        = 16'd59512;

endpackage
`default_nettype wire

// File: rtl/fc_layer_engine_mac.sv
`default_nettype none
// ============================================================================
// Module      : fc_mac_unit
// Description : Registered Q-format multiply-accumulate with bias load and
//               a saturating (optionally ReLU-clamped) output word.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_mac_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load_bias,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] c_y_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_y_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]    r_acc;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_shifted;
    logic signed [DATA_W-1:0]   w_sat;

    assign w_prod     = $signed({{DATA_W{x[DATA_W-1]}}, x}) * $signed({{DATA_W{w[DATA_W-1]}}, w});
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    // Bias is aligned to the product's 2*FRAC fractional bits.
    assign w_bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC;
    assign w_shifted  = r_acc >>> FRAC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (load_bias) begin
            r_acc <= w_bias_ext;
        end else if (acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    always_comb begin
        w_sat = w_shifted[DATA_W-1:0];
        if (w_shifted > c_y_max) begin
            w_sat = c_y_max[DATA_W-1:0];
        end else if (w_shifted < c_y_min) begin
            w_sat = c_y_min[DATA_W-1:0];
        end
    end

    generate
        if (RELU != 0) begin : g_relu
            assign y = w_sat[DATA_W-1] ? '0 : w_sat;
        end else begin : g_linear
            assign y = w_sat;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module      : fc_layer_engine
// Description : Fully connected layer sequencer; reads bias, x and W words
//               over a single-word RAM handshake and writes activated outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_engine
    import cnn_pkg::*;
#(
    parameter int N_IN   = 120,
    parameter int N_OUT  = 84,
    parameter int DATA_W = 16,
    parameter int FRAC   = FRAC_BITS,
    parameter int ACC_W  = 40,
    parameter int RELU   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    input  logic [15:0]       x_base,
    input  logic [15:0]       w_base,
    input  logic [15:0]       b_base,
    input  logic [15:0]       y_base,
    output logic              mem_enable,
    output logic              mem_write,
    output logic [15:0]       mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_finish,
    output logic              busy
);

    localparam int c_i_w = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int c_o_w = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [c_i_w-1:0] c_i_last = c_i_w'(N_IN - 1);
    localparam logic [c_o_w-1:0] c_o_last = c_o_w'(N_OUT - 1);
    localparam logic [c_i_w-1:0] c_i_one  = c_i_w'(1);
    localparam logic [c_o_w-1:0] c_o_one  = c_o_w'(1);

    fc_state_e                r_state;
    logic [c_o_w-1:0]         r_o_cnt;
    logic [c_i_w-1:0]         r_i_cnt;
    logic [15:0]              r_x_base;
    logic [15:0]              r_b_base;
    logic [15:0]              r_y_base;
    logic [15:0]              r_w_ptr;
    logic signed [DATA_W-1:0] r_x;
    logic signed [DATA_W-1:0] r_w;
    logic                     r_finish;
    logic                     r_busy;
    logic                     r_mem_enable;
    logic                     r_mem_write;
    logic [15:0]              r_mem_address;
    logic [DATA_W-1:0]        r_mem_wdata;

    logic                     w_xfer_done;
    logic                     w_load_bias;
    logic signed [DATA_W-1:0] w_y;

    assign w_xfer_done = r_mem_enable && mem_finish;
    assign w_load_bias = (r_state == FC_RD_BIAS) && w_xfer_done;

    fc_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W),
        .RELU   (RELU)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     (r_state == FC_IDLE),
        .load_bias (w_load_bias),
        .bias      (mem_rdata),
        .acc_en    (r_state == FC_MAC),
        .x         (r_x),
        .w         (r_w),
        .y         (w_y)
    );

    // Each RAM state raises enable on its first cycle and leaves on the
    // completion edge, which also drops enable and guarantees the idle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FC_IDLE;
            r_o_cnt       <= '0;
            r_i_cnt       <= '0;
            r_x_base      <= '0;
            r_b_base      <= '0;
            r_y_base      <= '0;
            r_w_ptr       <= '0;
            r_x           <= '0;
            r_w           <= '0;
            r_finish      <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_enable  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                FC_IDLE: begin
                    r_o_cnt <= '0;
                    r_i_cnt <= '0;
                    if (start) begin
                        r_x_base <= x_base;
                        r_b_base <= b_base;
                        r_y_base <= y_base;
                        r_w_ptr  <= w_base;
                        r_busy   <= 1'b1;
                        r_state  <= FC_RD_BIAS;
                    end
                end
                FC_RD_BIAS: begin
                    if (!r_mem_enable) begin
                        r_mem_enable  <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= r_b_base + 16'(r_o_cnt);
                    end else if (mem_finish) begin
                        r_mem_enable <= 1'b0;
                        r_i_cnt      <= '0;
                        r_state      <= FC_RD_X;
                    end
                end
                FC_RD_X: begin
                    if (!r_mem_enable) begin
                        r_mem_enable  <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= r_x_base + 16'(r_i_cnt);
                    end else if (mem_finish) begin
                        r_mem_enable <= 1'b0;
                        r_x          <= mem_rdata;
                        r_state      <= FC_RD_W;
                    end
                end
                FC_RD_W: begin
                    if (!r_mem_enable) begin
                        r_mem_enable  <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= r_w_ptr;
                    end else if (mem_finish) begin
                        r_mem_enable <= 1'b0;
                        r_w          <= mem_rdata;
                        r_w_ptr      <= r_w_ptr + 16'd1;
                        r_state      <= FC_MAC;
                    end
                end
                FC_MAC: begin
                    r_i_cnt <= r_i_cnt + c_i_one;
                    r_state <= (r_i_cnt == c_i_last) ? FC_WR_Y : FC_RD_X;
                end
                FC_WR_Y: begin
                    if (!r_mem_enable) begin
                        r_mem_enable  <= 1'b1;
                        r_mem_write   <= 1'b1;
                        r_mem_address <= r_y_base + 16'(r_o_cnt);
                        r_mem_wdata   <= w_y;
                    end else if (mem_finish) begin
                        r_mem_enable <= 1'b0;
                        r_mem_write  <= 1'b0;
                        if (r_o_cnt == c_o_last) begin
                            r_finish <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= FC_DONE;
                        end else begin
                            r_o_cnt <= r_o_cnt + c_o_one;
                            r_state <= FC_RD_BIAS;
                        end
                    end
                end
                FC_DONE: begin
                    if (!start) begin
                        r_finish <= 1'b0;
                        r_state  <= FC_IDLE;
                    end
                end
                default: begin
                    r_state <= FC_IDLE;
                end
            endcase
        end
    end

    assign finish      = r_finish;
    assign busy        = r_busy;
    assign mem_enable  = r_mem_enable;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;

    // w_xfer_done documents the completion condition shared by all RAM states.
    logic w_unused;
    assign w_unused = w_xfer_done;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fc_layer_engine
// Description : Directed self-checking bench, RELU and linear engines side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_engine;
    import cnn_pkg::*;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam logic [15:0] c_x_base = 16'h0010;
    localparam logic [15:0] c_w_base = 16'h0100;
    localparam logic [15:0] c_b_base = 16'h0020;
    localparam logic [15:0] c_y_base = 16'h0040;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, start_b;
    logic [15:0] x_base, w_base, b_base, y_base;
    logic        finish_a, en_a, wr_a, busy_a;
    logic        fin_a = 1'b0;
    logic [15:0] addr_a, wdata_a;
    logic [15:0] rdata_a = 16'h0;
    logic        finish_b, en_b, wr_b, busy_b;
    logic        fin_b = 1'b0;
    logic [15:0] addr_b, wdata_b;
    logic [15:0] rdata_b = 16'h0;

    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .finish(finish_a),
        .x_base(x_base), .w_base(w_base), .b_base(b_base), .y_base(y_base),
        .mem_enable(en_a), .mem_write(wr_a), .mem_address(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(rdata_a), .mem_finish(fin_a), .busy(busy_a)
    );

    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .finish(finish_b),
        .x_base(x_base), .w_base(w_base), .b_base(b_base), .y_base(y_base),
        .mem_enable(en_b), .mem_write(wr_b), .mem_address(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(rdata_b), .mem_finish(fin_b), .busy(busy_b)
    );

    // RAM models with a backdoor loader shared by both images
    logic        ld_en = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        lat_rand = 1'b0;
    logic [15:0] mem_a [0:511];
    logic [15:0] mem_b [0:511];
    logic [15:0] log_a [0:511];
    int rd_a = 0, wrc_a = 0, n_log_a = 0, lat_a = 0, lat_b = 0;
    logic fin_prev_a = 1'b0;
    int   rises_a = 0;

    always @(posedge clk) begin
        fin_a <= 1'b0;
        if (ld_en) mem_a[ld_addr] <= ld_data;
        if (en_a && !fin_a) begin
            if (lat_a == 0) begin
                fin_a <= 1'b1;
                log_a[n_log_a % 512] <= addr_a;
                n_log_a <= n_log_a + 1;
                if (wr_a) begin
                    mem_a[addr_a[8:0]] <= wdata_a;
                    wrc_a <= wrc_a + 1;
                end else begin
                    rdata_a <= mem_a[addr_a[8:0]];
                    rd_a <= rd_a + 1;
                end
                lat_a <= lat_rand ? int'($urandom_range(5, 0)) : 0;
            end else begin
                lat_a <= lat_a - 1;
            end
        end
    end

    always @(posedge clk) begin
        fin_b <= 1'b0;
        if (ld_en) mem_b[ld_addr] <= ld_data;
        if (en_b && !fin_b) begin
            if (lat_b == 0) begin
                fin_b <= 1'b1;
                if (wr_b) mem_b[addr_b[8:0]] <= wdata_b;
                else      rdata_b <= mem_b[addr_b[8:0]];
                lat_b <= lat_rand ? int'($urandom_range(5, 0)) : 0;
            end else begin
                lat_b <= lat_b - 1;
            end
        end
    end

    always @(posedge clk) begin
        fin_prev_a <= finish_a;
        if (finish_a && !fin_prev_a) rises_a <= rises_a + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int checks = 0;
    int passed = 0;
    logic [15:0] img_x [0:N_IN-1];
    logic [15:0] img_w [0:N_IN*N_OUT-1];
    logic [15:0] img_b [0:N_OUT-1];
    int rises0;

    task automatic load_word(input logic [8:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
    endtask

    task automatic load_image();
        for (int i = 0; i < N_IN; i++) load_word(9'(c_x_base + 16'(i)), img_x[i]);
        for (int i = 0; i < N_IN*N_OUT; i++) load_word(9'(c_w_base + 16'(i)), img_w[i]);
        for (int i = 0; i < N_OUT; i++) begin
            load_word(9'(c_b_base + 16'(i)), img_b[i]);
            load_word(9'(c_y_base + 16'(i)), 16'hDEAD);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic set_basic_image();
        img_x[0] = 16'h0100; img_x[1] = 16'h0200; img_x[2] = 16'hFF00; img_x[3] = 16'h0080;
        for (int i = 0; i < N_IN; i++) begin
            img_w[i] = 16'h0100;
            img_w[N_IN + i] = 16'hFE00;
        end
        img_b[0] = 16'h0040; img_b[1] = 16'h0000;
    endtask

    task automatic run_engines(input bit use_a, input bit use_b, output int cycles, output bit ok);
        @(negedge clk);
        start_a = use_a; start_b = use_b;
        cycles = 0; ok = 1'b0;
        while (!ok && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            ok = (!use_a || finish_a) && (!use_b || finish_b);
        end
    endtask

    task automatic stop_engines();
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({finish_a, en_a, wr_a, busy_a} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {finish_a, en_a, wr_a, busy_a});
        else passed++;
        chk16("reset_addr", addr_a, 16'h0000);
        chk16("reset_wdata", wdata_a, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        set_basic_image();
        load_image();
        rises0 = rises_a;
        run_engines(1'b1, 1'b1, cyc, ok);
        checks++;
        if (!ok) $display("FAIL basic_timeout: got %0d cycles without finish, expected finish", cyc);
        else passed++;
        checks++;
        if (cyc !== 69) $display("FAIL basic_cycles: got %0d expected 69", cyc);
        else passed++;
        chk16("basic_relu_y0", mem_a[c_y_base[8:0]], 16'h02C0);
        chk16("basic_relu_y1", mem_a[c_y_base[8:0] + 9'd1], 16'h0000);
        chk16("basic_lin_y0", mem_b[c_y_base[8:0]], 16'h02C0);
        chk16("basic_lin_y1", mem_b[c_y_base[8:0] + 9'd1], 16'hFB00);
    endtask

    task automatic test_hold_start();
        int log0, cyc; bit ok;
        log0 = n_log_a;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({finish_a, busy_a, en_a} !== 3'b100)
            $display("FAIL hold_flags: got %b expected 100", {finish_a, busy_a, en_a});
        else passed++;
        checks++;
        if (n_log_a !== log0) $display("FAIL hold_traffic: got %0d transactions expected 0", n_log_a - log0);
        else passed++;
        checks++;
        if (rises_a - rises0 !== 1) $display("FAIL finish_rises: got %0d expected 1", rises_a - rises0);
        else passed++;
        stop_engines();
        checks++;
        if (finish_a !== 1'b0) $display("FAIL finish_drop: got %b expected 0", finish_a);
        else passed++;
        load_image();
        run_engines(1'b1, 1'b0, cyc, ok);
        checks++;
        if (!ok) $display("FAIL rerun_timeout: got %0d cycles without finish, expected finish", cyc);
        else passed++;
        chk16("rerun_y0", mem_a[c_y_base[8:0]], 16'h02C0);
        chk16("rerun_y1", mem_a[c_y_base[8:0] + 9'd1], 16'h0000);
        stop_engines();
    endtask

    task automatic test_saturation();
        int cyc; bit ok;
        for (int i = 0; i < N_IN; i++) begin
            img_x[i] = 16'h7F00;
            img_w[i] = 16'h7F00;
            img_w[N_IN + i] = 16'h8100;
        end
        img_b[0] = 16'h0000; img_b[1] = 16'h0000;
        load_image();
        run_engines(1'b1, 1'b1, cyc, ok);
        checks++;
        if (!ok) $display("FAIL sat_timeout: got %0d cycles without finish, expected finish", cyc);
        else passed++;
        chk16("sat_relu_pos", mem_a[c_y_base[8:0]], 16'h7FFF);
        chk16("sat_relu_neg", mem_a[c_y_base[8:0] + 9'd1], 16'h0000);
        chk16("sat_lin_pos", mem_b[c_y_base[8:0]], 16'h7FFF);
        chk16("sat_lin_neg", mem_b[c_y_base[8:0] + 9'd1], 16'h8000);
        stop_engines();
    endtask

    task automatic test_random_latency();
        int rd0, wr0, log0, cyc, k, mism;
        bit ok;
        logic [15:0] exp_addr;
        set_basic_image();
        load_image();
        lat_rand = 1'b1;
        rd0 = rd_a; wr0 = wrc_a; log0 = n_log_a;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        x_base = 16'h0180; w_base = 16'h01A0; b_base = 16'h01C0; y_base = 16'h01E0;
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            ok = finish_a;
        end
        checks++;
        if (!ok) $display("FAIL rand_timeout: got %0d cycles without finish, expected finish", cyc);
        else passed++;
        chk16("rand_y0", mem_a[c_y_base[8:0]], 16'h02C0);
        chk16("rand_y1", mem_a[c_y_base[8:0] + 9'd1], 16'h0000);
        checks++;
        if (rd_a - rd0 !== N_OUT*(1 + 2*N_IN)) $display("FAIL rand_reads: got %0d expected %0d", rd_a - rd0, N_OUT*(1 + 2*N_IN));
        else passed++;
        checks++;
        if (wrc_a - wr0 !== N_OUT) $display("FAIL rand_writes: got %0d expected %0d", wrc_a - wr0, N_OUT);
        else passed++;
        mism = 0; k = 0;
        for (int o = 0; o < N_OUT; o++) begin
            exp_addr = c_b_base + 16'(o);
            if (log_a[(log0 + k) % 512] !== exp_addr) mism++;
            k++;
            for (int i = 0; i < N_IN; i++) begin
                exp_addr = c_x_base + 16'(i);
                if (log_a[(log0 + k) % 512] !== exp_addr) mism++;
                k++;
                exp_addr = c_w_base + 16'(o*N_IN + i);
                if (log_a[(log0 + k) % 512] !== exp_addr) mism++;
                k++;
            end
            exp_addr = c_y_base + 16'(o);
            if (log_a[(log0 + k) % 512] !== exp_addr) mism++;
            k++;
        end
        checks++;
        if (mism !== 0) $display("FAIL rand_addr_seq: got %0d wrong addresses expected 0", mism);
        else passed++;
        x_base = c_x_base; w_base = c_w_base; b_base = c_b_base; y_base = c_y_base;
        stop_engines();
        lat_rand = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int cyc; bit ok, hit;
        set_basic_image();
        load_image();
        @(negedge clk);
        start_a = 1'b1;
        hit = 1'b0; cyc = 0;
        while (!hit && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            hit = en_a && !wr_a && addr_a >= c_w_base + 16'd4 && addr_a <= c_w_base + 16'd7;
        end
        checks++;
        if (!hit || busy_a !== 1'b1) $display("FAIL midrun_reach: got hit=%b busy=%b expected 1 1", hit, busy_a);
        else passed++;
        @(negedge clk);
        reset = 1'b1; start_a = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({en_a, busy_a, finish_a} !== 3'b000)
            $display("FAIL midrun_abort: got %b expected 000", {en_a, busy_a, finish_a});
        else passed++;
        checks++;
        if (dut_a.r_state !== FC_IDLE) $display("FAIL midrun_state: got %0d expected %0d", dut_a.r_state, FC_IDLE);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        load_image();
        run_engines(1'b1, 1'b0, cyc, ok);
        checks++;
        if (!ok) $display("FAIL restart_timeout: got %0d cycles without finish, expected finish", cyc);
        else passed++;
        chk16("restart_y0", mem_a[c_y_base[8:0]], 16'h02C0);
        chk16("restart_y1", mem_a[c_y_base[8:0] + 9'd1], 16'h0000);
        stop_engines();
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        x_base = c_x_base; w_base = c_w_base; b_base = c_b_base; y_base = c_y_base;
        test_reset();
        test_basic();
        test_hold_start();
        test_saturation();
        test_random_latency();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
